sa_result_drain: RTL and testbench

Reader-side drain for the systolic array core's result interface. It watches the per-column result/valid ports and captures a complete (or flushed partial) tile of column results into a local buffer. It acknowledges the core with a single-cycle read pulse, then serializes the captured words onto one valid/ready stream tagged with column index and last-beat flag. It sits between the core's result outputs and the downstream writeback/host logic.

---
 rtl/sa_result_drain.sv | 95 +++++++++
 tb/tb_sa_result_drain.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// Captures one full (or flushed partial) result tile from the systolic array core, acks it with a single rread pulse,
// then streams the valid columns in ascending order on a valid/ready port; m_ready low freezes the current beat.
module sa_result_drain #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [OUTWIDTH-1:0]     r_in [0:ROWS-1],
    input  logic [0:ROWS-1]         rv_in,
    input  logic                    flush,
    output logic                    rread,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OUTWIDTH-1:0]     m_data,
    output logic [$clog2(ROWS)-1:0] m_col,
    output logic                    m_last,
    output logic                    busy
);
    localparam int COLW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, ACK, SEND} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [OUTWIDTH-1:0] tile_buf [0:ROWS-1];
    logic [ROWS-1:0]     mask;
    logic [ROWS-1:0]     low_bit;
    logic [COLW-1:0]     col;
    logic                last;
    logic                capture;

    // A flush with no valid columns is a no-op; all-ones wins regardless of flush.
    assign capture = (state == IDLE) && ((&rv_in) || (flush && (|rv_in)));

    // Isolate the lowest pending column; it is the final beat when nothing else is set.
    assign low_bit = mask & (~mask + ROWS'(1));
    assign last    = ((mask & ~low_bit) == '0);

    always_comb begin
        col = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (mask[i]) col = COLW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rread     = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_col     = '0;
        m_last    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (capture) state_nxt = ACK;
            end
            ACK: begin
                rread     = 1'b1;
                busy      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = tile_buf[col];
                m_col   = col;
                m_last  = last;
                if (m_ready && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mask <= '0;
            for (int i = 0; i < ROWS; i++) tile_buf[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < ROWS; i++) begin
                tile_buf[i] <= r_in[i];
                mask[i]     <= rv_in[i];
            end
        end else if (state == SEND && m_ready) begin
            mask <= mask & ~low_bit;
        end
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Randomized and directed bench for sa_result_drain with a tile-level reference model and beat scoreboard.
module tb_sa_result_drain;
    localparam int ROWS = 8;
    localparam int W    = 32;

    typedef struct packed {
        logic [ROWS-1:0]   m;
        logic [ROWS*W-1:0] d;
    } tile_t;

    typedef struct packed {
        logic [2:0]   col;
        logic [W-1:0] dat;
        logic         last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic [W-1:0]      r_in [0:ROWS-1];
    logic [0:ROWS-1]   rv_in;
    logic              flush;
    logic              rread;
    logic              m_valid;
    logic              m_ready;
    logic [W-1:0]      m_data;
    logic [2:0]        m_col;
    logic              m_last;
    logic              busy;

    logic [15:0]       r2_in [0:1];
    logic [0:1]        rv2_in;
    logic              flush2;
    logic              rread2;
    logic              m_valid2;
    logic              m_ready2;
    logic [15:0]       m_data2;
    logic [0:0]        m_col2;
    logic              m_last2;
    logic              busy2;

    int    n_pass = 0;
    int    n_checks = 0;
    int    rread_cnt = 0;
    int    beat_cnt = 0;
    int    ready_mode = 0;
    tile_t pend_q[$];
    beat_t exp_q[$];

    sa_result_drain #(.ROWS(ROWS), .OUTWIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .r_in(r_in), .rv_in(rv_in), .flush(flush),
        .rread(rread), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_col(m_col), .m_last(m_last), .busy(busy)
    );

    sa_result_drain #(.ROWS(2), .OUTWIDTH(16)) dut2 (
        .clk(clk), .rstn(rstn), .r_in(r2_in), .rv_in(rv2_in), .flush(flush2),
        .rread(rread2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
        .m_col(m_col2), .m_last(m_last2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a captured tile yields one beat per set column, ascending, last on the highest.
    task automatic expand(input tile_t t);
        int hi = -1;
        for (int c = 0; c < ROWS; c++) if (t.m[c]) hi = c;
        for (int c = 0; c < ROWS; c++)
            if (t.m[c]) exp_q.push_back('{col: 3'(c), dat: t.d[c*W +: W], last: (c == hi)});
    endtask

    initial begin
        int rphase = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       begin m_ready = (rphase % 4 == 0) || (rphase % 4 == 3); rphase++; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: beats are compared against the model; rread releases the next pending tile.
    logic  prev_stall = 1'b0;
    logic  prev_rread = 1'b0;
    beat_t prev_beat;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = '{col: m_col, dat: m_data, last: m_last};
        if (rstn) begin
            if (prev_stall) check("hold_stable", {m_valid, cur}, {1'b1, prev_beat});
            if (rread) begin
                rread_cnt++;
                check("rread_single_cycle", prev_rread, 0);
                check("no_overlap_at_rread", exp_q.size(), 0);
                check("rread_expected", pend_q.size() > 0, 1);
                if (pend_q.size() > 0) expand(pend_q.pop_front());
            end
            if (m_valid && m_ready) begin
                beat_cnt++;
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat", cur, e);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = cur;
            prev_rread = rread;
        end else begin
            prev_stall = 1'b0;
            prev_rread = 1'b0;
        end
    end

    task automatic issue(input logic [ROWS-1:0] m, input logic fl, input logic [ROWS*W-1:0] d);
        @(posedge clk);
        #1;
        for (int c = 0; c < ROWS; c++) begin
            r_in[c]  = d[c*W +: W];
            rv_in[c] = m[c];
        end
        flush = fl;
        if ((&m) || (fl && (|m))) pend_q.push_back('{m: m, d: d});
    endtask

    task automatic wait_rread();
        bit seen = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            seen = rread;
        end
        check("rread_within_bound", seen, 1);
    endtask

    // Core model: holds valids until rread, then drops them.
    task automatic send_tile(input logic [ROWS-1:0] m, input logic fl, input logic [ROWS*W-1:0] d);
        issue(m, fl, d);
        if ((&m) || (fl && (|m))) wait_rread();
        else repeat (4) @(negedge clk);
        rv_in = '0;
        flush = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 4000 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (pend_q.size() == 0) && !busy;
        end
        check("drain_within_bound", done, 1);
    endtask

    task automatic run2(input logic [1:0] m, input logic fl, input logic [15:0] d0, input logic [15:0] d1);
        logic [17:0] got[$];
        logic [17:0] exp[$];
        logic [15:0] dd [0:1];
        int rd = 0;
        int hi = -1;
        @(posedge clk);
        #1;
        r2_in[0] = d0; r2_in[1] = d1;
        rv2_in[0] = m[0]; rv2_in[1] = m[1];
        flush2 = fl;
        repeat (8) begin
            @(negedge clk);
            if (rread2) begin rd++; rv2_in = '0; flush2 = 1'b0; end
            if (m_valid2 && m_ready2) got.push_back({m_col2, m_data2, m_last2});
        end
        rv2_in = '0;
        flush2 = 1'b0;
        dd[0] = d0; dd[1] = d1;
        for (int c = 0; c < 2; c++) if (m[c]) hi = c;
        for (int c = 0; c < 2; c++) if (m[c]) exp.push_back({1'(c), dd[c], c == hi});
        check("w2_rread_count", rd, 1);
        check("w2_beat_count", got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) check("w2_beat", got[i], exp[i]);
    endtask

    initial begin
        logic [ROWS*W-1:0] d;
        logic [ROWS*W-1:0] dfull;
        logic [ROWS-1:0]   m;
        int rd_first, rd_n, first_v, last_busy, rc, bc, b0;
        bit hit;

        rstn = 1'b0; rv_in = '0; flush = 1'b0;
        rv2_in = '0; flush2 = 1'b0; m_ready2 = 1'b1;
        for (int c = 0; c < ROWS; c++) r_in[c] = '0;
        r2_in[0] = '0; r2_in[1] = '0;
        for (int c = 0; c < ROWS; c++) dfull[c*W +: W] = 32'h100 + 32'(c);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {rread, m_valid, m_data, m_col, m_last, busy}, 0);
        check("reset_outputs_w2", {rread2, m_valid2, m_data2, m_col2, m_last2, busy2}, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Full tile with cycle-accurate timing
        ready_mode = 0;
        issue(8'hFF, 1'b0, dfull);
        rd_first = -1; rd_n = 0; first_v = -1; last_busy = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (rread) begin if (rd_first < 0) rd_first = i; rd_n++; rv_in = '0; end
            if (m_valid && first_v < 0) first_v = i;
            if (busy) last_busy = i;
        end
        check("full_rread_cycle", rd_first, 2);
        check("full_rread_count", rd_n, 1);
        check("full_first_beat_cycle", first_v, 3);
        check("full_last_busy_cycle", last_busy, 10);
        drain();

        // Backpressure 1,0,0,1,...
        ready_mode = 1;
        send_tile(8'hFF, 1'b0, dfull);
        drain();

        // Partial flush on columns 1, 4, 6
        ready_mode = 0;
        rc = rread_cnt; bc = beat_cnt;
        for (int c = 0; c < ROWS; c++) d[c*W +: W] = $urandom();
        send_tile(8'b0101_0010, 1'b1, d);
        drain();
        check("flush_beat_count", beat_cnt - bc, 3);
        check("flush_rread_count", rread_cnt - rc, 1);

        // Flush with nothing valid does nothing
        rc = rread_cnt; bc = beat_cnt;
        send_tile(8'h00, 1'b1, d);
        repeat (6) @(negedge clk);
        check("empty_flush_rread", rread_cnt - rc, 0);
        check("empty_flush_beats", beat_cnt - bc, 0);

        // Back-to-back tiles: second is re-presented during the first's SEND
        ready_mode = 2;
        for (int c = 0; c < ROWS; c++) d[c*W +: W] = 32'hA000_0000 | 32'(c);
        send_tile(8'hFF, 1'b0, d);
        for (int c = 0; c < ROWS; c++) d[c*W +: W] = 32'hB000_0000 | 32'(c);
        send_tile(8'hFF, 1'b0, d);
        drain();

        // Reset mid-SEND after 3 beats, core keeps valids asserted
        ready_mode = 0;
        for (int c = 0; c < ROWS; c++) d[c*W +: W] = $urandom();
        rc = rread_cnt;
        b0 = beat_cnt;
        issue(8'hFF, 1'b0, d);
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(posedge clk);
            hit = (beat_cnt >= b0 + 3);
        end
        check("reset_reach_3_beats", hit, 1);
        #1 rstn = 1'b0;
        exp_q.delete();
        pend_q.push_back('{m: 8'hFF, d: d});
        @(posedge clk);
        @(negedge clk);
        check("midsend_reset_outputs", {rread, m_valid, m_data, m_col, m_last, busy}, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        wait_rread();
        rv_in = '0;
        drain();
        check("midsend_rread_total", rread_cnt - rc, 2);
        check("midsend_beat_total", beat_cnt - b0, 11);

        // Randomized tiles under random backpressure
        ready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = $urandom_range(0, 3);
            for (int c = 0; c < ROWS; c++) d[c*W +: W] = $urandom();
            m = (kind <= 1) ? 8'hFF : 8'($urandom());
            send_tile(m, (kind == 1) || (kind == 2), d);
        end
        drain();

        // Narrow instance: ROWS=2, OUTWIDTH=16
        run2(2'b11, 1'b0, 16'h1230, 16'h1231);
        run2(2'b10, 1'b1, 16'h5555, 16'hBEEF);

        check("final_queues_empty", exp_q.size() + pend_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
